// File: rtl/inst_loader_pkg.sv
// ============================================================================
// Module  : inst_pkg
// Brief   : Shared defaults and FSM state encoding for the instruction loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_pkg;

    localparam int unsigned c_DEPTH  = 64;
    localparam int unsigned c_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/inst_loader_if.sv
// ============================================================================
// Module  : inst_loader_if
// Brief   : Control, byte-stream and RAM write-port bundle of the loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface inst_loader_if import inst_pkg::*; #(
    parameter int ADDR_W = c_ADDR_W
);
    logic              start;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done
    );

    modport slave (
        input  start, abort, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
// ============================================================================
// Module  : byte_packer
// Brief   : MSB-first byte-to-word shift register with a wrapping byte count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_packer (
    input  wire logic        clk,
    input  wire logic        Reset,
    input  wire logic        clr,
    input  wire logic        shift,
    input  wire logic [7:0]  byte_in,
    output logic      [31:0] word,
    output logic             full
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    // clr only drops the count; the stale word is never written because
    // a write needs four fresh shifts.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_word  <= 32'd0;
            r_count <= 2'd0;
        end else if (clr) begin
            r_count <= 2'd0;
        end else if (shift) begin
            r_word  <= {r_word[23:0], byte_in};
            r_count <= r_count + 2'd1;
        end
    end

    assign word = r_word;
    assign full = (r_count == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module  : inst_loader
// Brief   : Packs a byte stream into 32-bit words and writes DEPTH of them
//           to an external instruction RAM port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_loader import inst_pkg::*; #(
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W
) (
    input  wire logic    clk,
    input  wire logic    Reset,
    inst_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_byte_ready;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_waddr;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_clr;
    logic              w_shift;
    logic              w_full;
    logic [31:0]       w_word;

    byte_packer u_packer (
        .clk     (clk),
        .Reset   (Reset),
        .clr     (w_clr),
        .shift   (w_shift),
        .byte_in (bus.byte_data),
        .word    (w_word),
        .full    (w_full)
    );

    always_comb begin
        w_next     = r_state;
        w_accept   = (r_state == LOAD) && bus.byte_valid;
        w_start_ok = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.abort;
        w_clr      = bus.abort || w_start_ok;
        w_shift    = w_accept && !bus.abort;

        case (r_state)
            IDLE, DONE: begin
                if (bus.abort)
                    w_next = IDLE;
                else if (bus.start)
                    w_next = LOAD;
            end
            LOAD: begin
                if (bus.abort)
                    w_next = IDLE;
                else if (w_accept && w_full)
                    w_next = WRITE;
            end
            WRITE: begin
                if (bus.abort)
                    w_next = IDLE;
                else if (r_waddr == c_LAST_ADDR)
                    w_next = DONE;
                else
                    w_next = LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_waddr      <= '0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == LOAD);
            r_we         <= (w_next == WRITE);
            r_busy       <= (w_next == LOAD) || (w_next == WRITE);
            r_done       <= (w_next == DONE);
            if (w_start_ok)
                r_waddr <= '0;
            else if ((r_state == WRITE) && (w_next == LOAD))
                r_waddr <= r_waddr + ADDR_W'(1);
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.we         = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = w_word;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module  : tb_inst_loader
// Brief   : Directed self-checking bench for inst_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_loader;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    inst_loader_if #(.ADDR_W(6)) bus ();

    inst_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0]  wr_addr [$];
    logic [31:0] wr_data [$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_addr.push_back(bus.waddr);
            wr_data.push_back(bus.wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
    endtask

    // Four bytes MSB first, then the WRITE cycle with a junk byte still offered.
    task automatic load_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--)
            send_byte(w[8*k +: 8]);
        bus.byte_data = 8'hEE;
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        Reset          = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("rst.byte_ready", bus.byte_ready, 0);
        check("rst.we",         bus.we,         0);
        check("rst.waddr",      bus.waddr,      0);
        check("rst.wdata",      bus.wdata,      0);
        check("rst.busy",       bus.busy,       0);
        check("rst.done",       bus.done,       0);

        // Single word
        pulse_start();
        check("w0.busy",       bus.busy,       1);
        check("w0.byte_ready", bus.byte_ready, 1);
        check("w0.waddr",      bus.waddr,      0);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        check("w0.we",         bus.we,         1);
        check("w0.waddr_wr",   bus.waddr,      0);
        check("w0.wdata",      bus.wdata,      32'h20010005);
        check("w0.ready_wr",   bus.byte_ready, 0);
        bus.byte_valid = 1'b0;
        tick();
        check("w0.we_off",     bus.we,         0);
        check("w0.ready_next", bus.byte_ready, 1);
        check("w0.waddr_next", bus.waddr,      1);
        check("w0.nwrites",    wr_addr.size(), 1);

        // Full program load
        pulse_abort();
        check("ab0.busy", bus.busy, 0);
        check("ab0.done", bus.done, 0);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int i = 0; i < 64; i++)
            load_word(32'h01000000 + i);
        check("full.done",       bus.done,       1);
        check("full.busy",       bus.busy,       0);
        check("full.waddr",      bus.waddr,      63);
        check("full.byte_ready", bus.byte_ready, 0);
        for (int i = 0; i < 8; i++)
            send_byte(8'h5A);
        bus.byte_valid = 1'b0;
        check("full.nwrites",    wr_addr.size(), 64);
        check("full.done_hold",  bus.done,       1);
        check("full.waddr_hold", bus.waddr,      63);
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            check($sformatf("full.addr%0d", i), wr_addr[i], i);
            check($sformatf("full.data%0d", i), wr_data[i], 32'h01000000 + i);
        end

        // Abort mid-word 5
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        check("ab.done_clr", bus.done,  0);
        check("ab.waddr0",   bus.waddr, 0);
        for (int i = 0; i < 5; i++)
            load_word(32'h05000000 + i);
        send_byte(8'h55);
        send_byte(8'h66);
        bus.byte_valid = 1'b0;
        pulse_abort();
        tick();
        tick();
        check("ab.busy",       bus.busy,       0);
        check("ab.done",       bus.done,       0);
        check("ab.byte_ready", bus.byte_ready, 0);
        check("ab.nwrites",    wr_addr.size(), 5);
        pulse_start();
        load_word(32'hA1B2C3D4);
        bus.byte_valid = 1'b0;
        check("ab.nwrites2",   wr_addr.size(), 6);
        if (wr_addr.size() >= 6) begin
            check("ab.restart_addr", wr_addr[5], 0);
            check("ab.restart_data", wr_data[5], 32'hA1B2C3D4);
        end

        // Reset on the 4th-byte edge
        pulse_abort();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        bus.byte_data = 8'h44;
        Reset = 1'b0;
        tick();
        check("rw.we",         bus.we,         0);
        check("rw.byte_ready", bus.byte_ready, 0);
        check("rw.waddr",      bus.waddr,      0);
        check("rw.wdata",      bus.wdata,      0);
        check("rw.busy",       bus.busy,       0);
        check("rw.done",       bus.done,       0);
        Reset = 1'b1;
        bus.byte_valid = 1'b0;
        tick();
        check("rw.we_after",   bus.we,         0);
        check("rw.nwrites",    wr_addr.size(), 6);

        // Gapped bytes with start pulsed mid-load
        pulse_start();
        load_word(32'h0BADF00D);
        bus.byte_valid = 1'b0;
        send_byte(8'hDE);
        bus.byte_valid = 1'b0; bus.byte_data = 8'h11; bus.start = 1'b1; tick(); bus.start = 1'b0;
        send_byte(8'hAD);
        bus.byte_valid = 1'b0; bus.byte_data = 8'h22; tick();
        send_byte(8'hBE);
        bus.byte_valid = 1'b0; bus.byte_data = 8'h33; bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("gap.we_early",  bus.we,    0);
        check("gap.busy",      bus.busy,  1);
        send_byte(8'hEF);
        check("gap.we",        bus.we,    1);
        check("gap.waddr",     bus.waddr, 1);
        check("gap.wdata",     bus.wdata, 32'hDEADBEEF);
        bus.byte_valid = 1'b0;
        tick();
        check("gap.waddr_next", bus.waddr,      2);
        check("gap.nwrites",    wr_addr.size(), 8);

        // abort beats start in IDLE
        pulse_abort();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("as.busy",       bus.busy,       0);
        check("as.byte_ready", bus.byte_ready, 0);
        tick();
        check("as.busy2",      bus.busy,       0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
